// File: rtl/eb1_iccm_dumper_pkg.sv
// eb1_iccm_dumper_pkg: state encoding and constants shared by the ICCM dumper and loader
package eb1_iccm_dumper_pkg;
  typedef enum logic [2:0] {
    S_IDLE, S_RD_REQ, S_RD_WAIT, S_TX_BYTE, S_TX_WAIT, S_FIN
  } state_t;
  localparam logic [31:0] EOF_WORD_DEF  = 32'h00000FFF;
  localparam int          ADDR_STEP_DEF = 2;
endpackage

// File: rtl/eb1_word_serializer.sv
// eb1_word_serializer: 32-bit word to MSB-first byte stream with byte index and last-byte flag
module eb1_word_serializer (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        load_i,
  input  logic        shift_i,
  input  logic [31:0] word_i,
  output logic [7:0]  byte_o,
  output logic        last_o
);
  logic [31:0] shreg_q;
  logic [1:0]  idx_q;
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      shreg_q <= '0;
      idx_q   <= '0;
    end else if (load_i) begin
      shreg_q <= word_i;
      idx_q   <= '0;
    end else if (shift_i) begin
      shreg_q <= {shreg_q[23:0], 8'h00};
      idx_q   <= idx_q + 2'd1;
    end
  assign byte_o = shreg_q[31:24];
  assign last_o = idx_q == 2'd3;
endmodule

// File: rtl/eb1_iccm_dumper.sv
// eb1_iccm_dumper: reads an ICCM word range and streams it MSB byte first to the UART transmitter
module eb1_iccm_dumper
  import eb1_iccm_dumper_pkg::*;
#(
  parameter int          ADDR_W    = 14,
  parameter int          ADDR_STEP = ADDR_STEP_DEF,
  parameter int          RD_LAT    = 1,
  parameter bit          SEND_EOF  = 1'b1,
  parameter logic [31:0] EOF_WORD  = EOF_WORD_DEF
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              abort_i,
  input  logic [ADDR_W-1:0] base_addr_i,
  input  logic [ADDR_W-1:0] word_cnt_i,
  output logic              iccm_re_o,
  output logic [ADDR_W-1:0] iccm_addr_o,
  input  logic [31:0]       iccm_rdata_i,
  output logic              tx_dv_o,
  output logic [7:0]        tx_byte_o,
  input  logic              tx_done_i,
  output logic              busy_o,
  output logic              done_o
);
  localparam int LW = RD_LAT > 1 ? $clog2(RD_LAT) : 1;
  state_t            state_q;
  logic [ADDR_W-1:0] addr_q, rem_q;
  logic [LW-1:0]     lat_q;
  logic              eof_q, re_q, dv_q, done_q;
  logic              last, rd_done, word_end, eof_ld, ld, sh;
  assign rd_done  = state_q == S_RD_WAIT && lat_q == LW'(RD_LAT - 1);
  assign word_end = state_q == S_TX_WAIT && tx_done_i && last;
  assign eof_ld   = SEND_EOF && ((state_q == S_IDLE && start_i && word_cnt_i == '0) ||
                                 (word_end && !eof_q && rem_q == ADDR_W'(1)));
  assign ld       = !abort_i && (rd_done || eof_ld);
  // the last byte is not shifted out, so tx_byte_o holds it until the next word loads
  assign sh       = !abort_i && state_q == S_TX_WAIT && tx_done_i && !last;
  eb1_word_serializer u_ser (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .load_i (ld),
    .shift_i(sh),
    .word_i (rd_done ? iccm_rdata_i : EOF_WORD),
    .byte_o (tx_byte_o),
    .last_o (last)
  );
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
      lat_q   <= '0;
      eof_q   <= 1'b0;
      re_q    <= 1'b0;
      dv_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      re_q   <= 1'b0;
      dv_q   <= 1'b0;
      done_q <= 1'b0;
      if (abort_i) state_q <= S_IDLE;
      else case (state_q)
        S_IDLE: if (start_i) begin
          addr_q <= base_addr_i;
          rem_q  <= word_cnt_i;
          eof_q  <= 1'b0;
          if (word_cnt_i != '0) begin
            state_q <= S_RD_REQ;
            re_q    <= 1'b1;
          end else if (SEND_EOF) begin
            eof_q   <= 1'b1;
            state_q <= S_TX_BYTE;
            dv_q    <= 1'b1;
          end else begin
            state_q <= S_FIN;
            done_q  <= 1'b1;
          end
        end
        S_RD_REQ: begin
          lat_q   <= '0;
          state_q <= S_RD_WAIT;
        end
        S_RD_WAIT: if (rd_done) begin
          state_q <= S_TX_BYTE;
          dv_q    <= 1'b1;
        end else lat_q <= lat_q + LW'(1);
        S_TX_BYTE: state_q <= S_TX_WAIT;
        S_TX_WAIT: if (tx_done_i) begin
          if (!last) begin
            state_q <= S_TX_BYTE;
            dv_q    <= 1'b1;
          end else if (eof_q) begin
            state_q <= S_FIN;
            done_q  <= 1'b1;
          end else begin
            rem_q  <= rem_q - ADDR_W'(1);
            addr_q <= addr_q + ADDR_W'(ADDR_STEP);
            if (rem_q != ADDR_W'(1)) begin
              state_q <= S_RD_REQ;
              re_q    <= 1'b1;
            end else if (SEND_EOF) begin
              eof_q   <= 1'b1;
              state_q <= S_TX_BYTE;
              dv_q    <= 1'b1;
            end else begin
              state_q <= S_FIN;
              done_q  <= 1'b1;
            end
          end
        end
        S_FIN: state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  assign iccm_re_o   = re_q;
  assign iccm_addr_o = addr_q;
  assign tx_dv_o     = dv_q;
  assign done_o      = done_q;
  assign busy_o      = state_q != S_IDLE;
endmodule

// File: tb/tb_eb1_iccm_dumper.sv
// tb_eb1_iccm_dumper: scoreboard bench for the ICCM dumper (default build and an RD_LAT=3, no-EOF build)
module tb_eb1_iccm_dumper;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  int vec = 0, mis = 0;
  logic [31:0] mem [0:16383];
  logic        st0 = 0, ab0 = 0, td0 = 0, re0, dv0, busy0, done0;
  logic        st1 = 0, ab1 = 0, td1 = 0, re1, dv1, busy1, done1;
  logic [13:0] base0 = 0, cnt0 = 0, addr0, base1 = 0, cnt1 = 0, addr1;
  logic [31:0] rd0, rd1, r1a, r1b;
  logic [7:0]  by0, by1;
  logic [7:0]  exp_b0[$], exp_b1[$];
  logic [13:0] exp_a0[$], exp_a1[$];
  int dv_cnt0 = 0, dv_cnt1 = 0, done_cnt0 = 0, done_cnt1 = 0;

  eb1_iccm_dumper u0 (
    .clk_i(clk), .rst_i(rst), .start_i(st0), .abort_i(ab0), .base_addr_i(base0),
    .word_cnt_i(cnt0), .iccm_re_o(re0), .iccm_addr_o(addr0), .iccm_rdata_i(rd0),
    .tx_dv_o(dv0), .tx_byte_o(by0), .tx_done_i(td0), .busy_o(busy0), .done_o(done0));
  eb1_iccm_dumper #(.RD_LAT(3), .SEND_EOF(1'b0)) u1 (
    .clk_i(clk), .rst_i(rst), .start_i(st1), .abort_i(ab1), .base_addr_i(base1),
    .word_cnt_i(cnt1), .iccm_re_o(re1), .iccm_addr_o(addr1), .iccm_rdata_i(rd1),
    .tx_dv_o(dv1), .tx_byte_o(by1), .tx_done_i(td1), .busy_o(busy1), .done_o(done1));

  // ICCM models: data is valid only in the exact RD_LAT-th cycle after the strobe
  always @(posedge clk) begin
    rd0 <= re0 ? mem[addr0] : 32'hA5A5A5A5;
    r1a <= re1 ? mem[addr1] : 32'h5A5A5A5A;
    r1b <= r1a;
    rd1 <= r1b;
  end

  always @(negedge clk) begin
    logic [7:0]  eb;
    logic [13:0] ea;
    if (dv0) begin
      dv_cnt0++; vec++;
      if (exp_b0.size() == 0) begin mis++; $display("FAIL byte0 got %h required none", by0); end
      else begin eb = exp_b0.pop_front(); if (by0 !== eb) begin mis++; $display("FAIL byte0 got %h required %h", by0, eb); end end
    end
    if (dv1) begin
      dv_cnt1++; vec++;
      if (exp_b1.size() == 0) begin mis++; $display("FAIL byte1 got %h required none", by1); end
      else begin eb = exp_b1.pop_front(); if (by1 !== eb) begin mis++; $display("FAIL byte1 got %h required %h", by1, eb); end end
    end
    if (re0) begin
      vec++;
      if (exp_a0.size() == 0) begin mis++; $display("FAIL read0 got %h required none", addr0); end
      else begin ea = exp_a0.pop_front(); if (addr0 !== ea) begin mis++; $display("FAIL read0 got %h required %h", addr0, ea); end end
    end
    if (re1) begin
      vec++;
      if (exp_a1.size() == 0) begin mis++; $display("FAIL read1 got %h required none", addr1); end
      else begin ea = exp_a1.pop_front(); if (addr1 !== ea) begin mis++; $display("FAIL read1 got %h required %h", addr1, ea); end end
    end
    if (done0) done_cnt0++;
    if (done1) done_cnt1++;
  end

  task automatic push_word(input int w, input logic [31:0] d);
    for (int k = 0; k < 4; k++)
      if (w != 0) exp_b1.push_back(d[31-8*k -: 8]);
      else exp_b0.push_back(d[31-8*k -: 8]);
  endtask

  task automatic kick(input int w, input logic [13:0] b, input logic [13:0] c);
    @(posedge clk); #1;
    if (w != 0) begin st1 = 1; base1 = b; cnt1 = c; end
    else begin st0 = 1; base0 = b; cnt0 = c; end
    @(posedge clk); #1;
    st0 = 0; st1 = 0;
  endtask

  // UART model: answers each tx_dv_o with tx_done_i after dly idle cycles
  task automatic serve(input int w, input int n, input int dly);
    int t;
    for (int i = 0; i < n; i++) begin
      t = 0;
      while (!(w != 0 ? dv1 : dv0) && t < 2000) begin @(posedge clk); #1; t++; end
      if (t >= 2000) return;
      @(posedge clk);
      repeat (dly) @(posedge clk);
      #1;
      if (w != 0) td1 = 1; else td0 = 1;
      @(posedge clk); #1;
      td0 = 0; td1 = 0;
    end
  endtask

  task automatic wait_idle(input int w);
    int t = 0;
    while ((w != 0 ? busy1 : busy0) && t < 3000) begin @(posedge clk); #1; t++; end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    repeat (3) @(posedge clk);
    #1;
    vec++; if ({re0, dv0, done0, busy0} !== 4'b0) begin mis++; $display("FAIL rst_ctl got %b required 0000", {re0, dv0, done0, busy0}); end
    vec++; if (by0 !== 8'h00) begin mis++; $display("FAIL rst_byte got %h required 00", by0); end
    vec++; if (addr0 !== 14'h0) begin mis++; $display("FAIL rst_addr got %h required 0000", addr0); end
    vec++; if ({re1, dv1, done1, busy1} !== 4'b0) begin mis++; $display("FAIL rst_ctl1 got %b required 0000", {re1, dv1, done1, busy1}); end
    rst = 0;
    repeat (2) @(posedge clk);
    #1;
    vec++; if ({re0, dv0, done0, busy0} !== 4'b0) begin mis++; $display("FAIL idle_ctl got %b required 0000", {re0, dv0, done0, busy0}); end
  endtask

  task automatic test_basic;
    int d = done_cnt0, v = dv_cnt0, lat = 1;
    mem[14'h10] = 32'hDEADBEEF; mem[14'h12] = 32'h01234567;
    exp_a0.push_back(14'h10); exp_a0.push_back(14'h12);
    push_word(0, 32'hDEADBEEF); push_word(0, 32'h01234567); push_word(0, 32'h00000FFF);
    kick(0, 14'h10, 14'd2);
    while (!dv0 && lat < 50) begin @(posedge clk); #1; lat++; end
    vec++; if (lat != 3) begin mis++; $display("FAIL first_dv_latency got %0d required 3", lat); end
    serve(0, 12, 0);
    wait_idle(0);
    vec++; if (done_cnt0 != d + 1) begin mis++; $display("FAIL basic_done got %0d required %0d", done_cnt0 - d, 1); end
    vec++; if (dv_cnt0 - v != 12) begin mis++; $display("FAIL basic_dv_count got %0d required 12", dv_cnt0 - v); end
    vec++; if (exp_b0.size() + exp_a0.size() != 0) begin mis++; $display("FAIL basic_left got %0d required 0", exp_b0.size() + exp_a0.size()); end
  endtask

  task automatic test_empty;
    int d = done_cnt0, t = 1;
    push_word(0, 32'h00000FFF);
    kick(0, 14'h123, 14'd0);
    serve(0, 4, 3);
    wait_idle(0);
    vec++; if (done_cnt0 != d + 1) begin mis++; $display("FAIL empty_done got %0d required 1", done_cnt0 - d); end
    vec++; if (exp_b0.size() != 0) begin mis++; $display("FAIL empty_left got %0d required 0", exp_b0.size()); end
    kick(1, 14'h55, 14'd0);
    while (!done1 && t < 10) begin @(posedge clk); #1; t++; end
    vec++; if (t > 2) begin mis++; $display("FAIL noeof_done_latency got %0d required <=2", t); end
    wait_idle(1);
    vec++; if (busy1 !== 1'b0) begin mis++; $display("FAIL noeof_busy got %b required 0", busy1); end
  endtask

  task automatic test_wrap;
    int d = done_cnt0;
    mem[14'h3FFE] = 32'hCAFEF00D; mem[14'h0000] = 32'h89ABCDEF;
    exp_a0.push_back(14'h3FFE); exp_a0.push_back(14'h0000);
    push_word(0, 32'hCAFEF00D); push_word(0, 32'h89ABCDEF); push_word(0, 32'h00000FFF);
    kick(0, 14'h3FFE, 14'd2);
    serve(0, 12, 1);
    wait_idle(0);
    vec++; if (done_cnt0 != d + 1) begin mis++; $display("FAIL wrap_done got %0d required 1", done_cnt0 - d); end
    vec++; if (exp_b0.size() + exp_a0.size() != 0) begin mis++; $display("FAIL wrap_left got %0d required 0", exp_b0.size() + exp_a0.size()); end
  endtask

  task automatic test_slow;
    int d = done_cnt0, v = dv_cnt0;
    mem[14'h20] = 32'h11223344;
    exp_a0.push_back(14'h20);
    push_word(0, 32'h11223344); push_word(0, 32'h00000FFF);
    kick(0, 14'h20, 14'd1);
    @(posedge clk); #1;
    td0 = 1; st0 = 1; base0 = 14'h100; cnt0 = 14'd5;
    @(posedge clk); #1;
    td0 = 0; st0 = 0;
    serve(0, 8, 100);
    wait_idle(0);
    vec++; if (done_cnt0 != d + 1) begin mis++; $display("FAIL slow_done got %0d required 1", done_cnt0 - d); end
    vec++; if (dv_cnt0 - v != 8) begin mis++; $display("FAIL slow_dv_count got %0d required 8", dv_cnt0 - v); end
    vec++; if (exp_b0.size() + exp_a0.size() != 0) begin mis++; $display("FAIL slow_left got %0d required 0", exp_b0.size() + exp_a0.size()); end
  endtask

  task automatic test_abort;
    int d = done_cnt0, v = dv_cnt0, t = 0;
    mem[14'h40] = 32'hF0E1D2C3; mem[14'h42] = 32'hB4A59687;
    mem[14'h44] = 32'h13579BDF; mem[14'h46] = 32'h2468ACE0;
    exp_a0.push_back(14'h40); exp_a0.push_back(14'h42);
    push_word(0, 32'hF0E1D2C3); exp_b0.push_back(8'hB4); exp_b0.push_back(8'hA5);
    kick(0, 14'h40, 14'd4);
    serve(0, 5, 2);
    while (!dv0 && t < 100) begin @(posedge clk); #1; t++; end
    @(posedge clk); #1;
    ab0 = 1;
    @(posedge clk); #1;
    ab0 = 0;
    vec++; if (busy0 !== 1'b0) begin mis++; $display("FAIL abort_busy got %b required 0", busy0); end
    td0 = 1;
    @(posedge clk); #1;
    td0 = 0;
    repeat (30) @(posedge clk);
    #1;
    vec++; if (done_cnt0 != d) begin mis++; $display("FAIL abort_no_done got %0d required 0", done_cnt0 - d); end
    vec++; if (dv_cnt0 - v != 6) begin mis++; $display("FAIL abort_dv_count got %0d required 6", dv_cnt0 - v); end
    vec++; if (exp_b0.size() + exp_a0.size() != 0) begin mis++; $display("FAIL abort_left got %0d required 0", exp_b0.size() + exp_a0.size()); end
    @(posedge clk); #1;
    st0 = 1; ab0 = 1; base0 = 14'h40; cnt0 = 14'd1;
    @(posedge clk); #1;
    st0 = 0; ab0 = 0;
    vec++; if (busy0 !== 1'b0) begin mis++; $display("FAIL abort_start_busy got %b required 0", busy0); end
    repeat (10) @(posedge clk);
    exp_a0.push_back(14'h40);
    push_word(0, 32'hF0E1D2C3); push_word(0, 32'h00000FFF);
    kick(0, 14'h40, 14'd1);
    serve(0, 8, 0);
    wait_idle(0);
    vec++; if (done_cnt0 != d + 1) begin mis++; $display("FAIL rerun_done got %0d required 1", done_cnt0 - d); end
    vec++; if (exp_b0.size() + exp_a0.size() != 0) begin mis++; $display("FAIL rerun_left got %0d required 0", exp_b0.size() + exp_a0.size()); end
  endtask

  task automatic test_reset_mid;
    int t = 0;
    exp_a0.push_back(14'h10); exp_b0.push_back(8'hDE);
    kick(0, 14'h10, 14'd1);
    while (!dv0 && t < 100) begin @(posedge clk); #1; t++; end
    @(posedge clk); #2;
    vec++; if (busy0 !== 1'b1) begin mis++; $display("FAIL pre_rst_busy got %b required 1", busy0); end
    rst = 1;
    #1;
    vec++; if ({re0, dv0, done0, busy0} !== 4'b0) begin mis++; $display("FAIL async_rst_ctl got %b required 0000", {re0, dv0, done0, busy0}); end
    vec++; if (by0 !== 8'h00 || addr0 !== 14'h0) begin mis++; $display("FAIL async_rst_data got %h/%h required 00/0000", by0, addr0); end
    @(posedge clk); #1;
    rst = 0;
    repeat (5) @(posedge clk);
    #1;
    vec++; if (exp_b0.size() + exp_a0.size() != 0 || busy0 !== 1'b0) begin mis++; $display("FAIL post_rst got %0d/%b required 0/0", exp_b0.size() + exp_a0.size(), busy0); end
  endtask

  task automatic test_lat3;
    int d = done_cnt1, lat = 1;
    mem[14'h50] = 32'hA1B2C3D4; mem[14'h52] = 32'h55667788;
    exp_a1.push_back(14'h50); exp_a1.push_back(14'h52);
    push_word(1, 32'hA1B2C3D4); push_word(1, 32'h55667788);
    kick(1, 14'h50, 14'd2);
    while (!dv1 && lat < 50) begin @(posedge clk); #1; lat++; end
    vec++; if (lat != 5) begin mis++; $display("FAIL lat3_first_dv got %0d required 5", lat); end
    serve(1, 8, 0);
    wait_idle(1);
    vec++; if (done_cnt1 != d + 1) begin mis++; $display("FAIL lat3_done got %0d required 1", done_cnt1 - d); end
    vec++; if (exp_b1.size() + exp_a1.size() != 0) begin mis++; $display("FAIL lat3_left got %0d required 0", exp_b1.size() + exp_a1.size()); end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_empty;
    test_wrap;
    test_slow;
    test_abort;
    test_reset_mid;
    test_lat3;
    $display("== %0d vectors applied, %0d miscompares ==", vec, mis);
    $finish;
  end
endmodule
